// File: rtl/fp_ci_pkg.sv
// Shared definitions for the FP custom-instruction dispatcher: opcodes, FSM
// encoding and per-opcode core latency.
package fp_ci_pkg;

  localparam logic [7:0] OP_SUB  = 8'd0;
  localparam logic [7:0] OP_MULT = 8'd1;
  localparam logic [7:0] OP_ADD  = 8'd2;
  localparam logic [7:0] OP_NEG  = 8'd3;

  localparam logic [31:0] FP_QNAN = 32'h7FC0_0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_CMPL = 2'd2
  } ci_state_e;

  function automatic int unsigned lat_of(input logic [7:0] op,
                                         input int unsigned sub_lat,
                                         input int unsigned mult_lat);
    case (op)
      OP_SUB, OP_ADD: return sub_lat;
      OP_MULT:        return mult_lat;
      default:        return 0;
    endcase
  endfunction

  function automatic logic is_legal(input logic [7:0] op);
    return op <= OP_NEG;
  endfunction

endpackage

// File: rtl/fp_op_bank.sv
// Add/sub and multiply cores fed from the latched operands, each modelled as a
// combinational IEEE-754 single datapath followed by a fixed-depth pipeline.
module fp_op_bank
  import fp_ci_pkg::*;
#(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned N_W      = 8,
  parameter int unsigned SUB_LAT  = 7,
  parameter int unsigned MULT_LAT = 5
) (
  input  logic              clock,
  input  logic              aclr_i,
  input  logic              clk_en_i,
  input  logic [N_W-1:0]    n_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [DATA_W-1:0] res_o
);

  function automatic logic [5:0] clz50(input logic [49:0] v);
    logic [5:0] c;
    logic       found;
    c     = 6'd0;
    found = 1'b0;
    for (int i = 49; i >= 0; i--) begin
      if (!found) begin
        if (v[i]) found = 1'b1;
        else      c = c + 6'd1;
      end
    end
    return c;
  endfunction

  // Round-to-nearest-even on a normalised 24-bit mantissa; underflow flushes to zero.
  function automatic logic [31:0] fp_pack(input logic sgn, input int e_in,
                                          input logic [23:0] m, input logic g,
                                          input logic st);
    logic [24:0] mr;
    int          e;
    mr = {1'b0, m};
    e  = e_in;
    if (g && (st || m[0])) mr = mr + 25'd1;
    if (mr[24]) begin
      mr = mr >> 1;
      e  = e + 1;
    end
    if (e <= 0)   return {sgn, 31'b0};
    if (e >= 255) return {sgn, 8'hFF, 23'b0};
    return {sgn, e[7:0], mr[22:0]};
  endfunction

  function automatic logic [31:0] fp_add(input logic [31:0] x, input logic [31:0] y);
    logic [31:0] big, sml;
    logic [7:0]  d8;
    logic [23:0] mb, ms;
    logic [49:0] lw, sw, sh, nrm;
    logic [50:0] s;
    logic        sticky;
    int          e;
    if (x[30:23] == 8'hFF || y[30:23] == 8'hFF) return FP_QNAN;
    if (x[30:0] >= y[30:0]) begin
      big = x; sml = y;
    end else begin
      big = y; sml = x;
    end
    mb = (big[30:23] == 8'd0) ? 24'd0 : {1'b1, big[22:0]};
    ms = (sml[30:23] == 8'd0) ? 24'd0 : {1'b1, sml[22:0]};
    d8 = big[30:23] - sml[30:23];
    lw = {mb, 26'b0};
    sw = {ms, 26'b0};
    if (d8 >= 8'd50) begin
      sh     = 50'd0;
      sticky = |ms;
    end else begin
      sh     = sw >> d8;
      sticky = ((sh << d8) != sw);
    end
    sh[0] = sh[0] | sticky;
    if (big[31] ^ sml[31]) s = {1'b0, lw} - {1'b0, sh};
    else                   s = {1'b0, lw} + {1'b0, sh};
    if (s == 51'd0) return {big[31] & sml[31], 31'b0};
    e = int'(big[30:23]);
    if (s[50]) begin
      nrm = s[50:1] | {49'b0, s[0]};
      e   = e + 1;
    end else begin
      nrm = s[49:0] << clz50(s[49:0]);
      e   = e - int'(clz50(s[49:0]));
    end
    return fp_pack(big[31], e, nrm[49:26], nrm[25], |nrm[24:0]);
  endfunction

  function automatic logic [31:0] fp_mul(input logic [31:0] x, input logic [31:0] y);
    logic        sgn;
    logic [47:0] p;
    int          e;
    if (x[30:23] == 8'hFF || y[30:23] == 8'hFF) return FP_QNAN;
    sgn = x[31] ^ y[31];
    if (x[30:23] == 8'd0 || y[30:23] == 8'd0) return {sgn, 31'b0};
    p = {24'b0, 1'b1, x[22:0]} * {24'b0, 1'b1, y[22:0]};
    e = int'(x[30:23]) + int'(y[30:23]) - 127;
    if (p[47]) return fp_pack(sgn, e + 1, p[47:24], p[23], |p[22:0]);
    return fp_pack(sgn, e, p[46:23], p[22], |p[21:0]);
  endfunction

  // The add/sub core always subtracts; ADD reaches it with datab's sign flipped.
  logic [DATA_W-1:0] core_b;
  logic [DATA_W-1:0] sub_in, mult_in;

  assign core_b  = (n_i == OP_ADD) ? {~b_i[31], b_i[30:0]} : b_i;
  assign sub_in  = fp_add(a_i, {~core_b[31], core_b[30:0]});
  assign mult_in = fp_mul(a_i, b_i);

  logic [DATA_W-1:0] sub_pipe_q  [SUB_LAT];
  logic [DATA_W-1:0] mult_pipe_q [MULT_LAT];

  always_ff @(posedge clock or posedge aclr_i) begin
    if (aclr_i) begin
      for (int i = 0; i < SUB_LAT; i++)  sub_pipe_q[i]  <= '0;
      for (int i = 0; i < MULT_LAT; i++) mult_pipe_q[i] <= '0;
    end else if (clk_en_i) begin
      sub_pipe_q[0]  <= sub_in;
      mult_pipe_q[0] <= mult_in;
      for (int i = 1; i < SUB_LAT; i++)  sub_pipe_q[i]  <= sub_pipe_q[i-1];
      for (int i = 1; i < MULT_LAT; i++) mult_pipe_q[i] <= mult_pipe_q[i-1];
    end
  end

  always_comb begin
    res_o = '0;
    case (n_i)
      OP_SUB, OP_ADD: res_o = sub_pipe_q[SUB_LAT-1];
      OP_MULT:        res_o = mult_pipe_q[MULT_LAT-1];
      OP_NEG:         res_o = {~a_i[31], a_i[30:0]};
      default:        res_o = '0;
    endcase
  end

endmodule

// File: rtl/fp_custom_dispatch.sv
// Multi-cycle FP custom-instruction unit: latches operands on start, counts the
// selected core's latency, then registers the result and pulses done.
module fp_custom_dispatch
  import fp_ci_pkg::*;
#(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned N_W      = 8,
  parameter int unsigned SUB_LAT  = 7,
  parameter int unsigned MULT_LAT = 5,
  parameter int unsigned CNT_W    = 4
) (
  input  logic              clock,
  input  logic              aclr_n,
  input  logic              clk_en,
  input  logic              start,
  input  logic [N_W-1:0]    n,
  input  logic [DATA_W-1:0] dataa,
  input  logic [DATA_W-1:0] datab,
  output logic [DATA_W-1:0] result,
  output logic              done,
  output logic              busy,
  output logic              illegal,
  output logic [1:0]        dbg_state_o
);

  // Handshake: start/n/dataa/datab are taken on an enabled edge only while idle
  // or in the completion cycle; done is high for exactly one enabled cycle.
  ci_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [N_W-1:0]    n_q, n_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              done_q, done_d;
  logic              illegal_q, illegal_d;
  logic [DATA_W-1:0] bank_res;
  logic              core_aclr;
  logic              accept;

  assign core_aclr = ~aclr_n;

  fp_op_bank #(
    .DATA_W   (DATA_W),
    .N_W      (N_W),
    .SUB_LAT  (SUB_LAT),
    .MULT_LAT (MULT_LAT)
  ) u_bank (
    .clock    (clock),
    .aclr_i   (core_aclr),
    .clk_en_i (clk_en),
    .n_i      (n_q),
    .a_i      (a_q),
    .b_i      (b_q),
    .res_o    (bank_res)
  );

  assign accept = start && (state_q == ST_IDLE || state_q == ST_CMPL);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    n_d       = n_q;
    a_d       = a_q;
    b_d       = b_q;
    result_d  = result_q;
    illegal_d = illegal_q;
    done_d    = 1'b0;
    case (state_q)
      ST_IDLE: ;
      ST_RUN: begin
        if (cnt_q == '0) state_d = ST_CMPL;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      ST_CMPL: begin
        result_d  = bank_res;
        illegal_d = !is_legal(n_q);
        done_d    = 1'b1;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // A new op accepted in the completion cycle overrides the return to idle.
    if (accept) begin
      n_d     = n;
      a_d     = dataa;
      b_d     = datab;
      cnt_d   = CNT_W'(lat_of(n, SUB_LAT, MULT_LAT));
      state_d = ST_RUN;
    end
  end

  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      n_q       <= '0;
      a_q       <= '0;
      b_q       <= '0;
      result_q  <= '0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else if (clk_en) begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      n_q       <= n_d;
      a_q       <= a_d;
      b_q       <= b_d;
      result_q  <= result_d;
      done_q    <= done_d;
      illegal_q <= illegal_d;
    end
  end

  assign result      = result_q;
  assign done        = done_q;
  assign illegal     = illegal_q;
  assign busy        = (state_q != ST_IDLE);
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_fp_custom_dispatch.sv
// Bench for fp_custom_dispatch: real-arithmetic reference model, directed
// scenarios and randomized single and back-to-back operations.
module tb_fp_custom_dispatch;

  logic        clock;
  logic        aclr_n;
  logic        clk_en;
  logic        start;
  logic [7:0]  op_n;
  logic [31:0] dataa;
  logic [31:0] datab;
  logic [31:0] result;
  logic        done;
  logic        busy;
  logic        illegal;
  logic [1:0]  dbg_state;

  int n_pass  = 0;
  int n_total = 0;

  logic [31:0] exp_q[$];
  logic        exp_ill_q[$];

  fp_custom_dispatch dut (
    .clock       (clock),
    .aclr_n      (aclr_n),
    .clk_en      (clk_en),
    .start       (start),
    .n           (op_n),
    .dataa       (dataa),
    .datab       (datab),
    .result      (result),
    .done        (done),
    .busy        (busy),
    .illegal     (illegal),
    .dbg_state_o (dbg_state)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: IEEE singles are widened to double, combined with real
  // arithmetic (exact for the operand ranges used) and rounded back to single.
  function automatic real sp2r(input logic [31:0] x);
    logic [10:0] e11;
    if (x[30:23] == 8'd0) return $bitstoreal({x[31], 63'b0});
    e11 = 11'(x[30:23]) + 11'd896;
    return $bitstoreal({x[31], e11, x[22:0], 29'b0});
  endfunction

  function automatic logic [31:0] r2sp(input real r);
    logic [63:0] bits;
    logic [24:0] m;
    int          e;
    bits = $realtobits(r);
    if (bits[62:0] == 63'd0) return {bits[63], 31'b0};
    e = int'(bits[62:52]) - 896;
    m = {2'b01, bits[51:29]};
    if (bits[28] && ((|bits[27:0]) || m[0])) m = m + 25'd1;
    if (m[24]) begin
      m = m >> 1;
      e = e + 1;
    end
    return {bits[63], e[7:0], m[22:0]};
  endfunction

  function automatic logic [31:0] ref_result(input logic [7:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    case (op)
      8'd0:    return r2sp(sp2r(a) - sp2r(b));
      8'd1:    return r2sp(sp2r(a) * sp2r(b));
      8'd2:    return r2sp(sp2r(a) + sp2r(b));
      8'd3:    return {~a[31], a[30:0]};
      default: return 32'd0;
    endcase
  endfunction

  function automatic int ref_lat(input logic [7:0] op);
    if (op == 8'd0 || op == 8'd2) return 7;
    if (op == 8'd1) return 5;
    return 0;
  endfunction

  function automatic logic [31:0] rand_sp();
    logic        s;
    logic [7:0]  e;
    logic [22:0] f;
    s = 1'($urandom_range(0, 1));
    e = 8'($urandom_range(120, 135));
    f = 23'($urandom);
    return {s, e, f};
  endfunction

  function automatic logic [7:0] rand_op();
    int r;
    r = int'($urandom_range(0, 4));
    if (r == 4) return 8'($urandom_range(4, 255));
    return 8'(r);
  endfunction

  // Issues one op from idle and checks done latency, result, illegal and the
  // single-cycle width of done.
  task automatic run_and_check(input string tag, input logic [7:0] op,
                               input logic [31:0] a, input logic [31:0] b);
    logic [31:0] exp_res;
    logic        exp_ill;
    int          exp_k;
    int          seen;
    exp_res = ref_result(op, a, b);
    exp_ill = (op > 8'd3);
    exp_k   = ref_lat(op) + 2;
    start = 1'b1; op_n = op; dataa = a; datab = b;
    @(posedge clock); @(negedge clock);
    start = 1'b0; dataa = $urandom; datab = $urandom; op_n = 8'($urandom);
    seen = -1;
    for (int k = 1; k <= 40 && seen < 0; k++) begin
      @(posedge clock); @(negedge clock);
      if (done === 1'b1) seen = k;
    end
    n_total++;
    if (seen != exp_k) $display("FAIL %s latency: got %0d cycles, expected %0d", tag, seen, exp_k);
    else n_pass++;
    n_total++;
    if (result !== exp_res) $display("FAIL %s result: got %h expected %h (op %0d a %h b %h)",
                                     tag, result, exp_res, op, a, b);
    else n_pass++;
    n_total++;
    if (illegal !== exp_ill) $display("FAIL %s illegal: got %b expected %b", tag, illegal, exp_ill);
    else n_pass++;
    @(posedge clock); @(negedge clock);
    n_total++;
    if (done !== 1'b0 || busy !== 1'b0)
      $display("FAIL %s after_done: got done=%b busy=%b expected 0/0", tag, done, busy);
    else n_pass++;
  endtask

  task automatic test_reset();
    aclr_n = 1'b0; clk_en = 1'b1; start = 1'b0; op_n = 8'd0; dataa = '0; datab = '0;
    #1;
    n_total++;
    if (result !== 32'd0) $display("FAIL reset result: got %h expected 00000000", result);
    else n_pass++;
    n_total++;
    if (done !== 1'b0) $display("FAIL reset done: got %b expected 0", done);
    else n_pass++;
    n_total++;
    if (busy !== 1'b0) $display("FAIL reset busy: got %b expected 0", busy);
    else n_pass++;
    n_total++;
    if (illegal !== 1'b0) $display("FAIL reset illegal: got %b expected 0", illegal);
    else n_pass++;
    @(negedge clock);
    aclr_n = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_directed();
    run_and_check("sub_1p5_2", 8'd0, 32'h3FC0_0000, 32'h4000_0000);
    run_and_check("mult_1p5_2", 8'd1, 32'h3FC0_0000, 32'h4000_0000);
    run_and_check("add_1_2", 8'd2, 32'h3F80_0000, 32'h4000_0000);
    run_and_check("neg_pi", 8'd3, 32'h4049_0FDB, 32'h1234_5678);
    run_and_check("illegal_55", 8'h55, 32'h3F80_0000, 32'h4000_0000);
    run_and_check("sub_cancel", 8'd0, 32'h4049_0FDB, 32'h4049_0FDB);
  endtask

  task automatic test_random();
    logic [7:0]  op;
    logic [31:0] a, b;
    for (int i = 0; i < 40; i++) begin
      op = rand_op();
      a  = rand_sp();
      b  = rand_sp();
      if ($urandom_range(0, 7) == 0) b = a;
      run_and_check("random", op, a, b);
    end
  endtask

  // A second start while busy must be dropped; the MULT result uses the original operands.
  task automatic test_drop_busy();
    int n_done;
    n_done = 0;
    start = 1'b1; op_n = 8'd1; dataa = 32'h3FC0_0000; datab = 32'h4000_0000;
    @(posedge clock); @(negedge clock);
    start = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clock); @(negedge clock);
      n_total++;
      if (busy !== (k <= 6)) $display("FAIL drop busy@%0d: got %b expected %b", k, busy, (k <= 6));
      else n_pass++;
      n_total++;
      if (done !== (k == 7)) $display("FAIL drop done@%0d: got %b expected %b", k, done, (k == 7));
      else n_pass++;
      if (done === 1'b1) begin
        n_done++;
        n_total++;
        if (result !== 32'h4040_0000) $display("FAIL drop result: got %h expected 40400000", result);
        else n_pass++;
      end
      if (k == 3) begin
        start = 1'b1; op_n = 8'd0; dataa = 32'hC2C8_0000;
      end
      if (k == 4) start = 1'b0;
    end
    n_total++;
    if (n_done != 1) $display("FAIL drop done_count: got %0d expected 1", n_done);
    else n_pass++;
  endtask

  task automatic test_stall();
    start = 1'b1; op_n = 8'd0; dataa = 32'h3FC0_0000; datab = 32'h4000_0000;
    @(posedge clock); @(negedge clock);
    start = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      @(posedge clock); @(negedge clock);
      n_total++;
      if (done !== (k == 13)) $display("FAIL stall done@%0d: got %b expected %b", k, done, (k == 13));
      else n_pass++;
      if (k == 13) begin
        n_total++;
        if (result !== 32'hBF00_0000) $display("FAIL stall result: got %h expected bf000000", result);
        else n_pass++;
      end
      if (k == 3) clk_en = 1'b0;
      if (k == 7) clk_en = 1'b1;
    end
    // Stalling while done is high must stretch the pulse.
    start = 1'b1; op_n = 8'd3; dataa = 32'h3F80_0000;
    @(posedge clock); @(negedge clock);
    start = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      @(posedge clock); @(negedge clock);
      n_total++;
      if (done !== (k >= 2 && k <= 5))
        $display("FAIL stretch done@%0d: got %b expected %b", k, done, (k >= 2 && k <= 5));
      else n_pass++;
      if (k == 2) begin
        n_total++;
        if (result !== 32'hBF80_0000) $display("FAIL stretch result: got %h expected bf800000", result);
        else n_pass++;
        clk_en = 1'b0;
      end
      if (k == 5) clk_en = 1'b1;
    end
  endtask

  task automatic test_reset_mid_op();
    start = 1'b1; op_n = 8'd0; dataa = 32'h3FC0_0000; datab = 32'h4000_0000;
    @(posedge clock); @(negedge clock);
    start = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clock); @(negedge clock);
    end
    aclr_n = 1'b0;
    #1;
    n_total++;
    if (busy !== 1'b0) $display("FAIL abort busy_in_reset: got %b expected 0", busy);
    else n_pass++;
    @(negedge clock);
    aclr_n = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clock); @(negedge clock);
      n_total++;
      if (done !== 1'b0) $display("FAIL abort done@%0d: got %b expected 0", k, done);
      else n_pass++;
    end
    n_total++;
    if (result !== 32'd0) $display("FAIL abort result: got %h expected 00000000", result);
    else n_pass++;
    n_total++;
    if (busy !== 1'b0) $display("FAIL abort busy: got %b expected 0", busy);
    else n_pass++;
    run_and_check("after_abort", 8'd1, 32'h3FC0_0000, 32'h4000_0000);
  endtask

  // Each new op is presented in the completion cycle of the previous one.
  task automatic test_back_to_back();
    logic [7:0]  ops [6];
    logic [31:0] as  [6];
    logic [31:0] bs  [6];
    int          st_e [7];
    int          idx;
    logic        exp_done;
    logic [31:0] r;
    logic        il;
    st_e[0] = 1;
    for (int i = 0; i < 6; i++) begin
      ops[i] = rand_op();
      as[i]  = rand_sp();
      bs[i]  = rand_sp();
      st_e[i+1] = st_e[i] + ref_lat(ops[i]) + 2;
      exp_q.push_back(ref_result(ops[i], as[i], bs[i]));
      exp_ill_q.push_back(ops[i] > 8'd3);
    end
    idx = 0;
    for (int e = 1; e <= st_e[6] + 2; e++) begin
      if (idx < 6 && st_e[idx] == e) begin
        start = 1'b1; op_n = ops[idx]; dataa = as[idx]; datab = bs[idx];
        idx++;
      end else begin
        start = 1'b0; op_n = 8'($urandom); dataa = $urandom; datab = $urandom;
      end
      @(posedge clock); @(negedge clock);
      exp_done = 1'b0;
      for (int j = 1; j <= 6; j++) if (st_e[j] == e) exp_done = 1'b1;
      n_total++;
      if (done !== exp_done) $display("FAIL b2b done@%0d: got %b expected %b", e, done, exp_done);
      else n_pass++;
      if (done === 1'b1) begin
        n_total++;
        if (exp_q.size() == 0) $display("FAIL b2b extra_done@%0d: got done with empty queue", e);
        else begin
          r  = exp_q.pop_front();
          il = exp_ill_q.pop_front();
          if (result !== r || illegal !== il)
            $display("FAIL b2b result@%0d: got %h/%b expected %h/%b", e, result, illegal, r, il);
          else n_pass++;
        end
      end
    end
    start = 1'b0;
    n_total++;
    if (exp_q.size() != 0) $display("FAIL b2b missing: got %0d outstanding expected 0", exp_q.size());
    else n_pass++;
    exp_q.delete();
    exp_ill_q.delete();
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_drop_busy();
    test_stall();
    test_reset_mid_op();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
